instr_mem_ctrl: RTL and testbench
=================================

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, SHALL set the word-address width; depth is 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 ld_en  input  1  SHALL be the loader write strobe.
REQ-006 ld_addr  input  ADDR_WIDTH  SHALL be the loader word address.
REQ-007 ld_data  input  DATA_WIDTH  SHALL be the loader write data.
REQ-008 ld_done  input  1  SHALL be a single-cycle pulse ending the boot load.
REQ-009 req_valid  input  1  SHALL indicate a fetch request is present.
REQ-010 req_addr  input  ADDR_WIDTH  SHALL be the fetch word address, taken from the PC.
REQ-011 req_ready  output  1  SHALL indicate that a fetch can be accepted this cycle.
REQ-012 rsp_valid  output  1  SHALL indicate rsp_instr holds a fetched instruction.
REQ-013 rsp_instr  output  DATA_WIDTH  SHALL carry the fetched instruction.
REQ-014 rsp_ready  input  1  SHALL indicate that the consumer accepts the response.
REQ-015 rsp_perr  output  1  SHALL flag a parity error on the current response.
REQ-016 booted  output  1  SHALL be high in state RUN.

Function
REQ-017 The FSM SHALL have two states, LOAD and RUN; reset enters LOAD.
REQ-018 In LOAD, ld_en=1 SHALL write ld_data to word ld_addr at the clock edge; req_ready SHALL be 0.
REQ-019 In LOAD, ld_done=1 SHALL move the FSM to RUN at that edge; a write in the same cycle SHALL still be performed.
REQ-020 In RUN, ld_en and ld_done SHALL be ignored; memory is read-only.
REQ-021 In RUN, req_ready SHALL equal (!rsp_valid || rsp_ready), combinationally.
REQ-022 A fetch is accepted when req_valid && req_ready; rsp_instr SHALL present mem[req_addr] with rsp_valid=1 on the next cycle (latency 1).
REQ-023 While rsp_valid && !rsp_ready, rsp_instr and rsp_perr SHALL hold stable and no new fetch SHALL be accepted.
REQ-024 rsp_valid SHALL clear after a handshake cycle (rsp_valid && rsp_ready) in which no new fetch is accepted.
REQ-025 Back-to-back fetches SHALL sustain one instruction per cycle while rsp_ready=1.
REQ-026 Addresses SHALL be word indices with no wrap logic; every ADDR_WIDTH-bit value is in range.
REQ-027 Reads of never-written words SHALL return the array contents unmodified; no defined value is required.

Reset
REQ-028 rst_n=0 SHALL immediately force state=LOAD, rsp_valid=0, rsp_instr=0, rsp_perr=0, booted=0 and req_ready=0.
REQ-029 Memory array contents SHALL NOT be cleared by reset.
REQ-030 Reset during RUN SHALL discard any pending response; the system SHALL require a new ld_done before fetching again.

Configuration
REQ-031 With macro IMEM_PARITY_EN defined, each word SHALL store an extra even-parity bit computed from ld_data at write time.
REQ-032 With IMEM_PARITY_EN defined, rsp_perr SHALL be 1 with a response when the recomputed parity mismatches the stored bit.
REQ-033 Without IMEM_PARITY_EN, no parity storage SHALL exist and rsp_perr SHALL be tied to 0.

Verification
REQ-034 Load words 0..3 = 0x20080005, 0x20090007, 0x01095020, 0xAC0A0000, then pulse ld_done; fetch addr 0..3 with rsp_ready=1 -> the same four words appear on consecutive cycles and booted=1.
REQ-035 Before ld_done, assert req_valid addr 0 -> req_ready=0 and rsp_valid stays 0.
REQ-036 Fetch addr 2 and hold rsp_ready=0 for 3 cycles -> rsp_instr=0x01095020 stable, req_ready=0, then one handshake with rsp_ready=1.
REQ-037 In RUN, ld_en=1 with ld_addr=0 and ld_data=0xFFFFFFFF, then fetch addr 0 -> response 0x20080005.
REQ-038 Same cycle ld_en=1 (addr 63, 0x0000000C) and ld_done=1, then fetch addr 63 -> 0x0000000C; fetches to addr 63 return to 0 with no fault.
REQ-039 Drop rst_n while rsp_valid=1 -> rsp_valid and booted drop immediately; with IMEM_PARITY_EN, force one flipped stored bit -> rsp_perr=1 with that response.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: boot-loaded instruction memory with a fetch port.
// After reset the block sits in LOAD, where a loader fills the array. An
// ld_done pulse moves it to RUN, where the array is read-only and serves
// instruction fetches with one cycle of latency.
// Optional feature macro: IMEM_PARITY_EN adds one even-parity bit per word
// and reports a mismatch on rsp_perr alongside the response.
//
// Handshake: a fetch transfers on any rising edge where req_valid && req_ready.
// A response transfers on any rising edge where rsp_valid && rsp_ready. While
// a response waits (rsp_valid && !rsp_ready), rsp_instr and rsp_perr hold and
// req_ready stays low. req_valid and req_addr are sampled only on a transfer.
module instr_mem_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_done,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_instr,
    input  logic                  rsp_ready,
    output logic                  rsp_perr,
    output logic                  booted,
    output logic [0:0]            dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en;
    logic                  fetch_fire;

    // Writes are only honoured while loading; in RUN the array is read-only.
    assign wr_en      = (state == ST_LOAD) && ld_en;
    // Accept a fetch only in RUN and only when the output slot is free or draining.
    assign req_ready  = (state == ST_RUN) && (!rsp_valid || rsp_ready);
    assign fetch_fire = req_valid && req_ready;
    assign booted     = (state == ST_RUN);
    assign dbg_state  = state;

    // Boot FSM: LOAD until ld_done, then RUN until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else if ((state == ST_LOAD) && ld_done) begin
            state <= ST_RUN;
        end
    end

    // Instruction array: no reset so the loaded image survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Response register: load on fetch, clear after a handshake with no new fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
        end else if (fetch_fire) begin
            rsp_valid <= 1'b1;
            rsp_instr <= mem[req_addr];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];

    // Parity array: even parity of the loaded word, captured at write time.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[ld_addr] <= ^ld_data;
        end
    end

    // Parity flag travels with the response and holds while it is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_perr <= 1'b0;
        end else if (fetch_fire) begin
            rsp_perr <= (^mem[req_addr]) ^ par_mem[req_addr];
        end
    end
`else
    assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: self-checking bench for instr_mem_ctrl.
// Drives inputs one time unit after the rising edge and samples on the
// falling edge. Fetch expectations come from a bench-side copy of the image.
module tb_instr_mem_ctrl;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_done;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_instr;
    logic          rsp_ready;
    logic          rsp_perr;
    logic          booted;
    logic [0:0]    dbg_state;

    instr_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_instr (rsp_instr),
        .rsp_ready (rsp_ready),
        .rsp_perr  (rsp_perr),
        .booted    (booted),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    int            stall_cycles = 0;
    bit            tb_loading = 1'b1;
    logic [DW-1:0] model_mem [64];
    bit            bad_par [64];
    logic [DW-1:0] exp_q[$];
    logic          exp_perr_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit done);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        ld_done = done;
        @(posedge clk);
        #1;
        ld_en   = 1'b0;
        ld_done = 1'b0;
        if (tb_loading) model_mem[a] = d;
        if (done) tb_loading = 1'b0;
    endtask

    // Presents a fetch and waits (bounded) for it to be accepted; leaves req_valid high.
    task automatic fetch(input logic [AW-1:0] a);
        int waited = 0;
        bit got = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!got && waited < 50) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(model_mem[a]);
                exp_perr_q.push_back(bad_par[a]);
                got = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!got) check("fetch_timeout", 32'd1, 32'd0);
        stall_cycles += waited;
        @(posedge clk);
        #1;
    endtask

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                check("rsp_instr", rsp_instr, exp_q.pop_front());
                check("rsp_perr", {31'd0, rsp_perr}, {31'd0, exp_perr_q.pop_front()});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        #2;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_instr", rsp_instr, 32'd0);
        check("rst_rsp_perr", {31'd0, rsp_perr}, 32'd0);
        check("rst_booted", {31'd0, booted}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fetch requests before boot must be refused.
        req_valid = 1'b1;
        req_addr  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("load_req_ready", {31'd0, req_ready}, 32'd0);
            check("load_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;

        // Boot image, then the last word written in the same cycle as ld_done.
        load_word(6'd0, 32'h2008_0005, 1'b0);
        load_word(6'd1, 32'h2009_0007, 1'b0);
        load_word(6'd2, 32'h0109_5020, 1'b0);
        load_word(6'd3, 32'hAC0A_0000, 1'b0);
        for (int i = 4; i < 63; i++) load_word(i[AW-1:0], $urandom(), 1'b0);
        check("pre_done_booted", {31'd0, booted}, 32'd0);
        load_word(6'd63, 32'h0000_000C, 1'b1);
        @(negedge clk);
        check("booted", {31'd0, booted}, 32'd1);
        check("dbg_state_run", {31'd0, dbg_state}, 32'd1);
`ifdef IMEM_PARITY_EN
        dut.par_mem[5] = ~dut.par_mem[5];
        bad_par[5] = 1'b1;
`endif
        @(posedge clk);
        #1;

        // Back-to-back fetches of the boot image with the consumer always ready.
        stall_cycles = 0;
        for (int i = 0; i < 4; i++) fetch(i[AW-1:0]);
        req_valid = 1'b0;
        check("b2b_stalls", stall_cycles, 32'd0);
        @(negedge clk);
        check("b2b_booted", {31'd0, booted}, 32'd1);
        @(posedge clk);
        #1;

        // Stalled response must hold and block new fetches.
        rsp_ready = 1'b0;
        fetch(6'd2);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_instr", rsp_instr, 32'h0109_5020);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Loader writes in RUN are ignored; top address works.
        load_word(6'd0, 32'hFFFF_FFFF, 1'b0);
        fetch(6'd0);
        fetch(6'd63);
        fetch(6'd0);
        req_valid = 1'b0;

        // Random fetches against random consumer back-pressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    fetch(AW'($urandom_range(0, 63)));
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                fetch(6'd5);
                req_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("drain_q_empty", exp_q.size(), 32'd0);
        check("drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset while a response is pending discards it and returns to LOAD.
        rsp_ready = 1'b0;
        fetch(6'd1);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rrst_booted", {31'd0, booted}, 32'd0);
        check("rrst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rrst_rsp_instr", rsp_instr, 32'd0);
        exp_q.delete();
        exp_perr_q.delete();
        tb_loading = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = '0;
        @(negedge clk);
        check("rrst_load_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        ld_done = 1'b1;
        @(posedge clk);
        #1 ld_done = 1'b0;
        tb_loading = 1'b0;
        // Memory contents survive reset.
        fetch(6'd0);
        fetch(6'd3);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
